// File: rtl/pc_fetch_unit_if.sv
// Bundle of program-memory, redirect and decode handshake signals around the fetch unit.
// Latency: none, pure wiring.
// Backpressure: carried by imem_ready (memory side) and instr_ready (decode side).
interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               fetch_err;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_target,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        output fetch_err
    );

    // Memory / decode / branch unit side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_target,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        input  fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter plus fetch queue between program memory and decode; optional macro FETCH_ALIGN_CHECK_EN.
// Latency: a memory response in cycle N is presented on instr_valid in cycle N+1.
// Backpressure: requests stop once queued + in-flight entries reach FQ_DEPTH; decode stalls with instr_ready.
module pc_fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int INSTR_BYTES = 2,
    parameter int RESET_PC    = 0,
    parameter int FQ_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);
    localparam logic [CW:0]       DEPTH_C    = (CW + 1)'(FQ_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     q_count_q, q_count_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    // Address FIFO: PCs of in-flight requests, popped by each response (kept or dropped)
    logic [FQ_DEPTH-1:0][ADDR_W-1:0] af_pc_q, af_pc_d;
    logic [PW-1:0]                   af_wr_q, af_wr_d, af_rd_q, af_rd_d;

    // Fetch queue: instruction word paired with its PC
    logic [FQ_DEPTH-1:0][INSTR_W-1:0] fq_data_q, fq_data_d;
    logic [FQ_DEPTH-1:0][ADDR_W-1:0]  fq_pc_q, fq_pc_d;
    logic [PW-1:0]                    fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;

    logic              accept, resp, push, pop, redir;
    logic [ADDR_W-1:0] redir_pc;
    logic [CW:0]       credit_used;

    // Request only from registered occupancy so imem_req never depends on an input
    assign credit_used   = {1'b0, q_count_q} + {1'b0, outstanding_q};
    assign bus.imem_req  = !rst && (credit_used < DEPTH_C);
    assign bus.imem_addr = pc_q;

    assign bus.instr_valid = (q_count_q != '0);
    assign bus.instr_data  = bus.instr_valid ? fq_data_q[fq_rd_q] : '0;
    assign bus.instr_pc    = bus.instr_valid ? fq_pc_q[fq_rd_q]   : '0;

    assign accept = bus.imem_req && bus.imem_ready;
    // A response with nothing in flight is a protocol violation and is ignored
    assign resp   = bus.imem_rvalid && (outstanding_q != '0);
    assign pop    = bus.instr_valid && bus.instr_ready;
    assign push   = resp && (discard_q == '0) && !redir;

    // Target with alignment bits cleared; identical to the target when already aligned
    assign redir_pc = bus.redirect_target & ~ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic fetch_err_q, fetch_err_d;

    assign misaligned  = |(bus.redirect_target & ALIGN_MASK);
    assign redir       = bus.redirect_valid && !misaligned;
    assign fetch_err_d = bus.redirect_valid && misaligned;
    assign bus.fetch_err = fetch_err_q;

    // One-cycle error pulse following a rejected redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_err_q <= 1'b0;
        else     fetch_err_q <= fetch_err_d;
    end
`else
    assign redir         = bus.redirect_valid;
    assign bus.fetch_err = 1'b0;
`endif

    // Next-state: PC advance, FIFO bookkeeping, and redirect flush which overrides everything
    always_comb begin
        pc_d          = pc_q;
        af_pc_d       = af_pc_q;
        af_wr_d       = af_wr_q;
        af_rd_d       = af_rd_q;
        fq_data_d     = fq_data_q;
        fq_pc_d       = fq_pc_q;
        fq_wr_d       = fq_wr_q;
        fq_rd_d       = fq_rd_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
        q_count_d     = q_count_q + CW'(push) - CW'(pop);

        if (accept) begin
            af_pc_d[af_wr_q] = pc_q;
            af_wr_d          = af_wr_q + 1'b1;
            pc_d             = pc_q + PC_INC;
        end
        if (resp) begin
            af_rd_d = af_rd_q + 1'b1;
            if (discard_q != '0) discard_d = discard_q - 1'b1;
        end
        if (push) begin
            fq_data_d[fq_wr_q] = bus.imem_rdata;
            fq_pc_d[fq_wr_q]   = af_pc_q[af_rd_q];
            fq_wr_d            = fq_wr_q + 1'b1;
        end
        if (pop) fq_rd_d = fq_rd_q + 1'b1;

        // Everything still in flight, including a request accepted this cycle, is dropped
        if (redir) begin
            pc_d      = redir_pc;
            discard_d = outstanding_d;
            q_count_d = '0;
            fq_wr_d   = '0;
            fq_rd_d   = '0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RST;
            q_count_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            af_pc_q       <= '0;
            af_wr_q       <= '0;
            af_rd_q       <= '0;
            fq_data_q     <= '0;
            fq_pc_q       <= '0;
            fq_wr_q       <= '0;
            fq_rd_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            q_count_q     <= q_count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            af_pc_q       <= af_pc_d;
            af_wr_q       <= af_wr_d;
            af_rd_q       <= af_rd_d;
            fq_data_q     <= fq_data_d;
            fq_pc_q       <= fq_pc_d;
            fq_wr_q       <= fq_wr_d;
            fq_rd_q       <= fq_rd_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: in-order memory with configurable latency and an instruction-stream reference.
// Latency: responses return lat_min..lat_max cycles after acceptance.
// Backpressure: imem_ready and instr_ready are driven per scenario, randomly in the soak test.
module tb_pc_fetch_unit;
    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    pc_fetch_unit #(
        .ADDR_W(16), .INSTR_W(16), .INSTR_BYTES(2), .RESET_PC(0), .FQ_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    mreq_t pend[$];
    int cyc = 0;
    int lat_min = 1, lat_max = 1;
    int n_chk = 0, n_pass = 0;

    // Observations of the last cycle
    logic o_req, o_acc, o_vld, o_hs, o_err;
    logic [15:0] o_addr, o_pc, o_data;

    // Reference: next PC decode should see, next PC memory should be asked for
    logic [15:0] exp_pc, iss_pc;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A3C;
    endfunction

    // One clock: drive inputs after negedge, sample #1 later, track requests in the memory model
    task automatic step(input logic mem_rdy, input logic dec_rdy, input logic rd_v, input logic [15:0] rd_t);
        int due;
        bus.imem_ready      = mem_rdy;
        bus.instr_ready     = dec_rdy;
        bus.redirect_valid  = rd_v;
        bus.redirect_target = rd_t;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memfn(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        o_req  = bus.imem_req;
        o_addr = bus.imem_addr;
        o_vld  = bus.instr_valid;
        o_pc   = bus.instr_pc;
        o_data = bus.instr_data;
        o_err  = bus.fetch_err;
        o_acc  = o_req && mem_rdy;
        o_hs   = o_vld && dec_rdy;
        if (o_acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (pend.size() > 0 && due < pend[$].due) due = pend[$].due;
            pend.push_back('{o_addr, due});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit keep_pend);
        rst = 1'b1;
        bus.imem_ready = 0; bus.instr_ready = 0; bus.redirect_valid = 0;
        bus.redirect_target = '0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
        if (!keep_pend) pend.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc = RST_PC;
        iss_pc = RST_PC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 0; bus.instr_ready = 0; bus.redirect_valid = 0;
        bus.redirect_target = '0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else n_pass++;
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_vld: got %b want 0", bus.instr_valid); else n_pass++;
        n_chk++; if (bus.instr_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", bus.instr_data); else n_pass++;
        n_chk++; if (bus.instr_pc !== 16'h0) $display("FAIL rst_pc: got %h want 0000", bus.instr_pc); else n_pass++;
        n_chk++; if (bus.fetch_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.fetch_err); else n_pass++;
        n_chk++; if (bus.imem_addr !== RST_PC) $display("FAIL rst_addr: got %h want %h", bus.imem_addr, RST_PC); else n_pass++;
    endtask

    task automatic test_throughput();
        do_reset(0); lat_min = 1; lat_max = 1;
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 16'h0);
            if (i < 3) begin
                n_chk++;
                if (o_req !== 1'b1 || o_addr !== RST_PC + 16'(2 * i))
                    $display("FAIL thr_addr%0d: req=%b addr=%h want req=1 addr=%h", i, o_req, o_addr, RST_PC + 16'(2 * i));
                else n_pass++;
            end
            n_chk++;
            if (i < 2) begin
                if (o_vld !== 1'b0) $display("FAIL thr_early_vld%0d: got %b want 0", i, o_vld); else n_pass++;
            end else begin
                if (o_hs !== 1'b1 || o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL thr_instr%0d: vld=%b pc=%h data=%h want vld=1 pc=%h data=%h", i, o_vld, o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
            end
            if (o_hs) exp_pc += 16'd2;
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, n_hs = 0;
        bit first_acc = 0;
        do_reset(0); lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 16'h0);
            if (o_acc) acc++;
        end
        n_chk++; if (acc !== 4) $display("FAIL bp_accepts: got %0d want 4", acc); else n_pass++;
        n_chk++; if (o_req !== 1'b0) $display("FAIL bp_req_stop: got %b want 0", o_req); else n_pass++;
        n_chk++; if (o_vld !== 1'b1) $display("FAIL bp_vld_held: got %b want 1", o_vld); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_acc && !first_acc) begin
                first_acc = 1;
                n_chk++; if (o_addr !== 16'h0008) $display("FAIL bp_resume_addr: got %h want 0008", o_addr); else n_pass++;
            end
            if (o_hs) begin
                n_hs++;
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL bp_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (first_acc !== 1'b1) $display("FAIL bp_resume_timeout: got %b want 1", first_acc); else n_pass++;
        n_chk++; if (n_hs < 5) $display("FAIL bp_drain_count: got %0d want >=5", n_hs); else n_pass++;
    endtask

    task automatic test_redirect_latency();
        int n_hs = 0;
        do_reset(0); lat_min = 3; lat_max = 3;
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        n_chk++; if (pend.size() !== 2) $display("FAIL rl_inflight: got %0d want 2", pend.size()); else n_pass++;
        step(1, 1, 1, 16'h0100);
        n_chk++; if (o_hs !== 1'b0) $display("FAIL rl_early_hs: got %b want 0", o_hs); else n_pass++;
        exp_pc = 16'h0100;
        step(1, 1, 0, 16'h0);
        n_chk++; if (o_vld !== 1'b0) $display("FAIL rl_vld_after: got %b want 0", o_vld); else n_pass++;
        n_chk++; if (o_req !== 1'b1 || o_addr !== 16'h0100) $display("FAIL rl_target_req: req=%b addr=%h want req=1 addr=0100", o_req, o_addr); else n_pass++;
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_hs) begin
                n_hs++;
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL rl_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (n_hs < 10) $display("FAIL rl_count: got %0d want >=10", n_hs); else n_pass++;
    endtask

    task automatic test_wrap();
        bit wrap_req = 0, wrap_ins = 0;
        logic [15:0] last_acc = 16'h1, last_hs = 16'h1;
        do_reset(0); lat_min = 1; lat_max = 2;
        step(1, 1, 1, 16'hFFFC);
        exp_pc = 16'hFFFC; iss_pc = 16'hFFFC;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_acc) begin
                n_chk++;
                if (o_addr !== iss_pc) $display("FAIL wr_addr: got %h want %h", o_addr, iss_pc); else n_pass++;
                if (last_acc == 16'hFFFE && o_addr == 16'h0000) wrap_req = 1;
                last_acc = o_addr;
                iss_pc += 16'd2;
            end
            if (o_hs) begin
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL wr_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                if (last_hs == 16'hFFFE && o_pc == 16'h0000) wrap_ins = 1;
                last_hs = o_pc;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (wrap_req !== 1'b1) $display("FAIL wr_req_wrap: got %b want 1", wrap_req); else n_pass++;
        n_chk++; if (wrap_ins !== 1'b1) $display("FAIL wr_instr_wrap: got %b want 1", wrap_ins); else n_pass++;
    endtask

    task automatic test_redirect_rvalid_reset();
        int n_hs = 0;
        do_reset(0); lat_min = 2; lat_max = 2;
        for (int k = 0; k < 10 && !(pend.size() > 0 && pend[0].due <= cyc); k++) step(1, 1, 0, 16'h0);
        n_chk++;
        if (!(pend.size() > 0 && pend[0].due <= cyc)) $display("FAIL rr_setup_timeout: got 0 want 1"); else n_pass++;
        step(1, 1, 1, 16'h0200);
        if (o_hs) begin
            n_chk++;
            if (o_pc !== exp_pc) $display("FAIL rr_redir_hs: pc=%h want %h", o_pc, exp_pc); else n_pass++;
        end
        exp_pc = 16'h0200;
        step(1, 1, 0, 16'h0);
        n_chk++; if (o_vld !== 1'b0) $display("FAIL rr_vld_after: got %b want 0", o_vld); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_hs) begin
                n_hs++;
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL rr_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (n_hs < 2) $display("FAIL rr_count: got %0d want >=2", n_hs); else n_pass++;
        // Asynchronous reset in the middle of a burst, memory keeps its stale responses
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL rr_rst_vld: got %b want 0", bus.instr_valid); else n_pass++;
        n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rr_rst_req: got %b want 0", bus.imem_req); else n_pass++;
        n_chk++; if (bus.imem_addr !== RST_PC) $display("FAIL rr_rst_pc: got %h want %h", bus.imem_addr, RST_PC); else n_pass++;
        n_chk++; if (pend.size() == 0) $display("FAIL rr_stale_setup: got 0 pending want >0"); else n_pass++;
        do_reset(1);
        for (int k = 0; k < 12 && pend.size() > 0; k++) begin
            step(0, 1, 0, 16'h0);
            n_chk++;
            if (o_vld !== 1'b0 || o_addr !== RST_PC)
                $display("FAIL rr_stale_ignored: vld=%b addr=%h want vld=0 addr=%h", o_vld, o_addr, RST_PC);
            else n_pass++;
        end
        n_hs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_hs) begin
                n_hs++;
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL rr_post_rst: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (n_hs < 3) $display("FAIL rr_post_rst_count: got %0d want >=3", n_hs); else n_pass++;
    endtask

    task automatic test_align();
        int n_hs = 0;
        do_reset(0); lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 16'h0);
            if (o_hs) exp_pc += 16'd2;
        end
        step(1, 1, 1, 16'h0103);
        if (o_hs) exp_pc += 16'd2;
        exp_pc = ALIGN_CHK ? exp_pc : 16'h0102;
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 0, 16'h0);
            if (i < 2) begin
                n_chk++;
                if (o_err !== (i == 0 ? ALIGN_CHK : 1'b0))
                    $display("FAIL al_err%0d: got %b want %b", i, o_err, (i == 0 ? ALIGN_CHK : 1'b0));
                else n_pass++;
            end
            if (o_hs) begin
                n_hs++;
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL al_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
        end
        n_chk++; if (n_hs < 8) $display("FAIL al_count: got %0d want >=8", n_hs); else n_pass++;
    endtask

    task automatic test_random();
        logic mr, dr, rv, mis, after_redir = 0, err_exp = 0;
        logic [15:0] tgt;
        do_reset(0); lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            mr  = ($urandom % 4) != 0;
            dr  = ($urandom % 3) != 0;
            rv  = ($urandom % 20) == 0;
            tgt = 16'($urandom);
            step(mr, dr, rv, tgt);
            if (o_acc) begin
                n_chk++;
                if (o_addr !== iss_pc) $display("FAIL rnd_addr: got %h want %h", o_addr, iss_pc); else n_pass++;
                iss_pc += 16'd2;
            end
            if (after_redir) begin
                n_chk++;
                if (o_vld !== 1'b0) $display("FAIL rnd_vld_after_redir: got %b want 0", o_vld); else n_pass++;
            end
            if (o_hs) begin
                n_chk++;
                if (o_pc !== exp_pc || o_data !== memfn(exp_pc))
                    $display("FAIL rnd_instr: pc=%h data=%h want pc=%h data=%h", o_pc, o_data, exp_pc, memfn(exp_pc));
                else n_pass++;
                exp_pc += 16'd2;
            end
            n_chk++;
            if (o_err !== err_exp) $display("FAIL rnd_err: got %b want %b", o_err, err_exp); else n_pass++;
            mis         = (tgt & 16'h0001) != 16'h0;
            err_exp     = rv && mis && ALIGN_CHK;
            after_redir = rv && !(mis && ALIGN_CHK);
            if (after_redir) begin
                exp_pc = tgt & 16'hFFFE;
                iss_pc = tgt & 16'hFFFE;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_redirect_latency();
        test_wrap();
        test_redirect_rvalid_reset();
        test_align();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and instruction-fetch front end.
- Replaces the fixed 16-bit, PC+2-only counter with:
  - a configurable-width PC
  - redirect (branch/jump) support
  - a request/response handshake to program memory, with arbitrary in-order read latency
  - a FQ_DEPTH-entry fetch queue that feeds decode through a valid/ready handshake
- Sits between the program memory and the decode stage in top.

Parameters:
ADDR_W, 16, PC / memory address width in bits
INSTR_W, 16, instruction width in bits
INSTR_BYTES, 2, PC increment per instruction; power of 2
RESET_PC, 0, PC value loaded on reset; must be INSTR_BYTES-aligned
FQ_DEPTH, 4, fetch queue entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (current PC)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid; responses return in request order
imem_rdata  in  INSTR_W  read data
redirect_valid  in  1  one-cycle redirect strobe
redirect_target  in  ADDR_W  new PC on redirect
instr_valid  out  1  fetch queue head valid
instr_data  out  INSTR_W  head instruction
instr_pc  out  ADDR_W  address of head instruction
instr_ready  in  1  decode consumes head
fetch_err  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset and clock:
  - Reset rst, asynchronous, active-high; clock clk.
  - All state updates on posedge clk.
- Reset values:
  - PC = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - imem_req = 0 while rst is asserted.
  - instr_valid = 0, instr_data = 0, instr_pc = 0, fetch_err = 0.
- Request issue:
  - imem_req = !rst && (q_count + outstanding < FQ_DEPTH).
  - imem_req is driven from registered state only; it has no combinational path from any input.
  - imem_addr = PC.
  - A request is accepted on imem_req && imem_ready. On acceptance: PC <= PC + INSTR_BYTES, mod 2^ADDR_W (wraps silently), and outstanding increments.
  - The request PC is pushed into an internal FQ_DEPTH-deep address FIFO so instr_pc can be paired with its response.
- Response:
  - On imem_rvalid: outstanding decrements, and the address FIFO pops.
  - If discard > 0: discard decrements and the data is dropped.
  - Otherwise {imem_rdata, popped PC} is written to the fetch queue.
  - imem_rvalid with outstanding == 0 is a protocol violation; the response is ignored and no counter moves.
- Decode handshake:
  - The head entry is consumed on instr_valid && instr_ready.
  - Queue write-to-read latency is 1 cycle: rvalid in cycle N gives instr_valid in cycle N+1.
  - Simultaneous push and pop when full is impossible by credit rule. When the queue is non-empty, push and pop in the same cycle keep q_count unchanged.
- Redirect (priority over all other PC updates):
  - PC <= redirect_target.
  - Fetch queue is flushed.
  - discard <= outstanding (after same-cycle increment/decrement), so every in-flight response is dropped.
  - A request accepted in the redirect cycle counts as in-flight and is discarded.
  - A response arriving in the redirect cycle is discarded.
  - A head handshake completed in the redirect cycle is considered consumed.
  - First request to the target is issued in the cycle after the redirect at the earliest; instr_valid is 0 the cycle after the redirect.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Throughput: 1 instruction/cycle sustained with a 1-cycle memory and instr_ready held high.
- Reset mid-operation: all state clears immediately; later responses from the pre-reset requests are ignored (they hit outstanding == 0).
- Counter widths: q_count, outstanding and discard are $clog2(FQ_DEPTH+1) bits each.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect_target with any of the low log2(INSTR_BYTES) bits set is rejected.
  - PC, queue and discard are unchanged, as if no redirect occurred.
  - fetch_err pulses high for exactly 1 cycle, registered, in the cycle after the strobe.
- Undefined:
  - The low alignment bits of redirect_target are forced to 0 and the redirect proceeds normally.
  - fetch_err is tied 0.

Test Plan:
- Reset release, 1-cycle memory, instr_ready=1 -> imem_addr 0x0000, 0x0002, 0x0004…; instr_pc sequence matches one per cycle from cycle 2; instr_data equals memory contents.
- instr_ready=0 for 10 cycles, FQ_DEPTH=4 -> exactly 4 requests accepted, then imem_req=0; releasing ready drains 4 in order, then fetch resumes at 0x0008.
- Memory latency 3 cycles, redirect to 0x0100 with 2 requests outstanding -> both responses dropped; first instr_pc after redirect = 0x0100; no stale data ever reaches instr_valid.
- PC = 0xFFFE, ADDR_W=16 -> next request address 0x0000; instr_pc 0xFFFE then 0x0000.
- Redirect and imem_rvalid in the same cycle, plus rst asserted mid-burst -> response discarded; after rst, PC = RESET_PC, instr_valid = 0, late rvalid ignored.
- FETCH_ALIGN_CHECK_EN defined, redirect to 0x0103 -> fetch_err = 1 for one cycle, fetch continues at the old PC. Undefined: fetch restarts at 0x0102.
